// File: rtl/cmp_gen_pkg.sv
// Shared types for the comparator operand generator.
// Relation codes, FSM states and the LFSR default seed.
package cmp_gen_pkg;

   typedef enum logic [1:0] {
      REL_LT   = 2'b00,
      REL_EQ   = 2'b01,
      REL_GT   = 2'b10,
      REL_RSVD = 2'b11
   } rel_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GEN  = 2'b01,
      OUT  = 2'b10
   } state_t;

   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

   // An all-zero LFSR would lock up, so zero seeds fall back to the default.
   function automatic logic [15:0] seed_fix(input logic [15:0] s);
      return (s == 16'h0000) ? LFSR_DEFAULT : s;
   endfunction

endpackage

// File: rtl/cmp_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting left.
// Loads its seed on reset and steps only when enabled.
module cmp_gen_lfsr16
   import cmp_gen_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] state
);

   localparam logic [15:0] INIT = seed_fix(SEED);

   logic fb;

   assign fb = state[15] ^ state[13] ^ state[12] ^ state[10];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= INIT;
      end else if (en) begin
         state <= {state[14:0], fb};
      end
   end

endmodule

// File: rtl/cmp_operand_gen.sv
// Produces an operand pair (a, b) satisfying a requested relation,
// drawing pseudo-random candidates from an LFSR.
module cmp_operand_gen
   import cmp_gen_pkg::*;
#(
   parameter int          WIDTH = 4,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [1:0]       req_rel,
   output logic             req_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [1:0]       out_rel,
   output logic [15:0]      out_cnt,
   output logic             err
);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } pair_t;

   state_t           state;
   state_t           state_nx;
   rel_t             rel_q;
   logic [15:0]      lfsr;
   logic             step;
   logic             accept;
   logic             rsvd;
   logic             hs;
   logic [WIDTH-1:0] cand_x;
   logic [WIDTH-1:0] cand_y;
   pair_t            fixed;

   // Equal candidates are nudged by one away from the range limit.
   function automatic pair_t fixup(
      input rel_t             rel,
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y
   );
      pair_t            p;
      logic [WIDTH-1:0] mx;
      mx  = '1;
      p.a = x;
      p.b = x;
      case (rel)
         REL_LT: begin
            if (x < y) begin
               p.a = x;
               p.b = y;
            end else if (x > y) begin
               p.a = y;
               p.b = x;
            end else if (x == mx) begin
               p.a = x - WIDTH'(1);
               p.b = x;
            end else begin
               p.a = x;
               p.b = x + WIDTH'(1);
            end
         end
         REL_GT: begin
            if (x > y) begin
               p.a = x;
               p.b = y;
            end else if (x < y) begin
               p.a = y;
               p.b = x;
            end else if (x == '0) begin
               p.a = WIDTH'(1);
               p.b = '0;
            end else begin
               p.a = x;
               p.b = x - WIDTH'(1);
            end
         end
         default: begin
            p.a = x;
            p.b = x;
         end
      endcase
      return p;
   endfunction

   cmp_gen_lfsr16 #(
      .SEED(SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .en   (step),
      .state(lfsr)
   );

   assign cand_x = lfsr[WIDTH-1:0];
   assign cand_y = lfsr[2*WIDTH-1:WIDTH];
   assign fixed  = fixup(rel_q, cand_x, cand_y);

   assign rsvd   = (req_rel == REL_RSVD);
   assign accept = req_valid & req_ready;
   assign hs     = out_valid & out_ready;

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      out_valid = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid && !rsvd) begin
               state_nx = GEN;
            end
         end
         GEN: begin
            step     = 1'b1;
            state_nx = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rel_q   <= REL_LT;
         out_a   <= '0;
         out_b   <= '0;
         out_rel <= 2'b00;
         out_cnt <= 16'h0000;
         err     <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept && rsvd) begin
            err <= 1'b1;
         end
         if (accept && !rsvd) begin
            rel_q <= rel_t'(req_rel);
         end
         if (state == GEN) begin
            out_a   <= fixed.a;
            out_b   <= fixed.b;
            out_rel <= rel_q;
         end
         if (hs) begin
            out_cnt <= out_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_cmp_operand_gen.sv
// Bench for cmp_operand_gen: four seeds side by side, directed
// boundary cases, then a random soak against a reference model.
module tb_cmp_operand_gen;

   localparam int W = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [1:0] req_rel = 2'b00;
   logic       out_ready = 1'b0;

   logic         req_ready [4];
   logic         out_valid [4];
   logic [W-1:0] out_a     [4];
   logic [W-1:0] out_b     [4];
   logic [1:0]   out_rel   [4];
   logic [15:0]  out_cnt   [4];
   logic         err       [4];

   int passed = 0;
   int total  = 0;

   logic [15:0] m_lfsr = 16'hACE1;

   always #5 clk = ~clk;

   cmp_operand_gen #(.WIDTH(W), .SEED(16'h0000)) u0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_rel(req_rel),
      .req_ready(req_ready[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready), .out_a(out_a[0]), .out_b(out_b[0]),
      .out_rel(out_rel[0]), .out_cnt(out_cnt[0]), .err(err[0]));

   cmp_operand_gen #(.WIDTH(W), .SEED(16'h0055)) u1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_rel(req_rel),
      .req_ready(req_ready[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready), .out_a(out_a[1]), .out_b(out_b[1]),
      .out_rel(out_rel[1]), .out_cnt(out_cnt[1]), .err(err[1]));

   cmp_operand_gen #(.WIDTH(W), .SEED(16'h00F0)) u2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_rel(req_rel),
      .req_ready(req_ready[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready), .out_a(out_a[2]), .out_b(out_b[2]),
      .out_rel(out_rel[2]), .out_cnt(out_cnt[2]), .err(err[2]));

   cmp_operand_gen #(.WIDTH(W), .SEED(16'h00FF)) u3 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_rel(req_rel),
      .req_ready(req_ready[3]), .out_valid(out_valid[3]),
      .out_ready(out_ready), .out_a(out_a[3]), .out_b(out_b[3]),
      .out_rel(out_rel[3]), .out_cnt(out_cnt[3]), .err(err[3]));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: LFSR step and the relation fix-up, in plain integer form.
   function automatic logic [15:0] m_next(input logic [15:0] l);
      logic fb;
      fb = l[15] ^ l[13] ^ l[12] ^ l[10];
      return {l[14:0], fb};
   endfunction

   function automatic logic [7:0] m_pair(input logic [15:0] l, input int rel);
      int x, y, a, b;
      x = int'(l[3:0]);
      y = int'(l[7:4]);
      a = x;
      b = x;
      if (rel == 0) begin
         if (x < y)       begin a = x;     b = y;     end
         else if (x > y)  begin a = y;     b = x;     end
         else if (x == 15) begin a = 14;   b = 15;    end
         else             begin a = x;     b = x + 1; end
      end else if (rel == 2) begin
         if (x > y)       begin a = x;     b = y;     end
         else if (x < y)  begin a = y;     b = x;     end
         else if (x == 0) begin a = 1;     b = 0;     end
         else             begin a = x;     b = x - 1; end
      end
      return {a[3:0], b[3:0]};
   endfunction

   function automatic logic rel_ok(input int a, input int b, input int r);
      return (r == 0 && a < b) || (r == 1 && a == b) || (r == 2 && a > b);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_lfsr = 16'hACE1;
   endtask

   task automatic chk_pair(input string tag, input int i,
                           input logic [3:0] ea, input logic [3:0] eb,
                           input logic [1:0] er);
      chk(tag, {22'd0, out_a[i], out_b[i], out_rel[i]}, {22'd0, ea, eb, er});
   endtask

   // Issue one non-reserved request and stop in OUT; u0 checked vs model.
   task automatic txn(input logic [1:0] rel, input logic ordy);
      logic [7:0] exp;
      req_valid = 1'b1;
      req_rel   = rel;
      out_ready = ordy;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("gen_no_valid", out_valid[0], 0);
      chk("gen_busy", req_ready[0], 0);
      @(posedge clk);
      #1;
      chk("out_valid", out_valid[0], 1);
      exp = m_pair(m_lfsr, int'(rel));
      m_lfsr = m_next(m_lfsr);
      chk_pair("u0_model", 0, exp[7:4], exp[3:0], rel);
   endtask

   initial begin
      logic [9:0]  held;
      logic [15:0] cnt0;
      logic [7:0]  p1;
      logic [7:0]  exp;
      logic        r;
      int          rel;
      int          hs;

      do_reset();
      for (int i = 0; i < 4; i++) begin
         chk("rst_ready", req_ready[i], 1);
         chk("rst_valid", out_valid[i], 0);
         chk("rst_pair", {out_a[i], out_b[i], out_rel[i]}, 0);
         chk("rst_cnt", out_cnt[i], 0);
         chk("rst_err", err[i], 0);
      end

      txn(2'b01, 1'b1);
      chk_pair("eq_55", 1, 4'h5, 4'h5, 2'b01);
      chk_pair("eq_ace1", 0, 4'h1, 4'h1, 2'b01);
      @(posedge clk);
      #1;
      chk("eq_cnt", out_cnt[1], 1);
      chk("eq_done_valid", out_valid[1], 0);
      chk("eq_done_ready", req_ready[1], 1);

      do_reset();
      txn(2'b00, 1'b1);
      chk_pair("lt_55", 1, 4'h5, 4'h6, 2'b00);
      chk_pair("lt_f0", 2, 4'h0, 4'hF, 2'b00);
      chk_pair("lt_ff_max", 3, 4'hE, 4'hF, 2'b00);
      chk_pair("lt_seed0", 0, 4'h1, 4'hE, 2'b00);
      @(posedge clk);
      #1;

      do_reset();
      txn(2'b10, 1'b1);
      chk_pair("gt_f0_swap", 2, 4'hF, 4'h0, 2'b10);
      chk_pair("gt_seed0", 0, 4'hE, 4'h1, 2'b10);
      chk_pair("gt_55", 1, 4'h5, 4'h4, 2'b10);
      chk_pair("gt_ff", 3, 4'hF, 4'hE, 2'b10);
      @(posedge clk);
      #1;

      req_valid = 1'b1;
      req_rel   = 2'b11;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("rsvd_err", err[0], 1);
      chk("rsvd_ready", req_ready[0], 1);
      chk("rsvd_valid", out_valid[0], 0);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rsvd_no_out", out_valid[0], 0);
      end
      txn(2'b01, 1'b1);
      @(posedge clk);
      #1;
      chk("rsvd_err_sticky", err[0], 1);
      chk("rsvd_cnt", out_cnt[0], 2);

      txn(2'b10, 1'b0);
      held = {out_a[0], out_b[0], out_rel[0]};
      cnt0 = out_cnt[0];
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp_hold", {out_a[0], out_b[0], out_rel[0]}, held);
         chk("bp_busy", {out_valid[0], req_ready[0]}, 2'b10);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_cnt", out_cnt[0], cnt0 + 16'd1);
      chk("bp_valid", out_valid[0], 0);
      @(posedge clk);
      #1;
      chk("bp_cnt_once", out_cnt[0], cnt0 + 16'd1);

      do_reset();
      txn(2'b00, 1'b0);
      p1 = {out_a[0], out_b[0]};
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", out_valid[0], 0);
      chk("arst_ready", req_ready[0], 1);
      chk("arst_cnt", out_cnt[0], 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_lfsr = 16'hACE1;
      txn(2'b00, 1'b1);
      chk("arst_repeat", {out_a[0], out_b[0]}, p1);
      @(posedge clk);
      #1;

      do_reset();
      hs = 0;
      for (int n = 0; n < 10000; n++) begin
         rel = $urandom_range(0, 3);
         req_valid = 1'b1;
         req_rel   = 2'(rel);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         if (rel == 3) continue;
         @(posedge clk);
         #1;
         exp = m_pair(m_lfsr, rel);
         m_lfsr = m_next(m_lfsr);
         chk_pair("soak_pair", 0, exp[7:4], exp[3:0], 2'(rel));
         for (int i = 0; i < 4; i++) begin
            chk("soak_rel", rel_ok(int'(out_a[i]), int'(out_b[i]),
                int'(out_rel[i])), 1);
         end
         for (int k = 0; k < 64; k++) begin
            r = ($urandom_range(0, 3) != 0) || (k == 63);
            out_ready = r;
            @(posedge clk);
            #1;
            if (r) break;
         end
         hs++;
      end
      chk("soak_cnt", out_cnt[0], 16'(hs));
      chk("soak_idle", req_ready[0], 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
